// File: rtl/enc_pro_stream_if.sv
// Message-in / codeword-out stream bundle for the RS parity generator.
interface enc_pro_stream_if #(
  parameter int LANES = 4,
  parameter int SYM_W = 8
);
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*SYM_W-1:0] s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [LANES*SYM_W-1:0] m_data;
  logic                   m_first;
  logic                   m_last;
  logic                   m_par;
  logic                   err;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_first, m_last, m_par, err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_first, m_last, m_par, err
  );
endinterface

// File: rtl/enc_pro_stream.sv
// Streaming systematic RS parity generator: message beats pass through with zero latency, parity beats
// follow the cycle after the last message beat; m_ready low freezes state and output in both phases.
module enc_pro_stream #(
  parameter int                              SYM_W   = 8,
  parameter logic [SYM_W:0]                  PRI_POL = 'h11D,
  parameter int                              MES_LEN = 239,
  parameter int                              PAR_LEN = 16,
  parameter int                              LANES   = 4,
  parameter logic [PAR_LEN-1:0][SYM_W-1:0]   GEN_POL = {8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209,
                                                        8'd30, 8'd8, 8'd163, 8'd65, 8'd41, 8'd229,
                                                        8'd98, 8'd50, 8'd36, 8'd59}
) (
  input logic             clk,
  input logic             rst,
  enc_pro_stream_if.slave bus
);

  localparam int R         = (MES_LEN % LANES == 0) ? LANES : (MES_LEN % LANES);
  localparam int MSG_BEATS = (MES_LEN + LANES - 1) / LANES;
  localparam int PAR_BEATS = PAR_LEN / LANES;
  localparam int CNT_W     = $clog2((MSG_BEATS > PAR_BEATS) ? MSG_BEATS : PAR_BEATS) + 1;

  if (PAR_LEN % LANES != 0) begin : g_bad_lanes
    $error("PAR_LEN must be a multiple of LANES");
  end
  if (LANES < 1 || LANES > PAR_LEN) begin : g_bad_lane_cnt
    $error("LANES must be in 1..PAR_LEN");
  end

  typedef logic [LANES-1:0][SYM_W-1:0]   beat_t;
  typedef logic [PAR_LEN-1:0][SYM_W-1:0] par_t;
  typedef enum logic {MSG, PAR} state_t;

  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? PRI_POL[SYM_W-1:0] : '0);
    end
    return acc;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  par_t             par_q;
  par_t             par_upd;
  beat_t            s_beat;
  beat_t            msg_beat;
  logic [SYM_W-1:0] fb;
  logic             beat0;
  logic             msg_end;
  logic             par_end;
  logic             s_xfer;
  logic             err_q;

  assign beat0   = (beat_cnt == '0);
  assign msg_end = (beat_cnt == CNT_W'(MSG_BEATS - 1));
  assign par_end = (beat_cnt == CNT_W'(PAR_BEATS - 1));
  assign s_beat  = bus.s_data;
  assign s_xfer  = bus.s_valid && bus.s_ready;

  // Lanes above the short first beat's message symbols are padding and never reach the codeword.
  always_comb begin
    msg_beat = s_beat;
    for (int l = R; l < LANES; l++) begin
      if (beat0) msg_beat[l] = '0;
    end
  end

  // Beat 0 always starts from a clean register so no residue of an aborted frame can leak in.
  always_comb begin
    par_upd = beat0 ? '0 : par_q;
    fb      = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      fb = msg_beat[l] ^ par_upd[PAR_LEN-1];
      for (int j = PAR_LEN - 1; j > 0; j--) begin
        par_upd[j] = par_upd[j-1] ^ gf_mul(fb, GEN_POL[j]);
      end
      par_upd[0] = gf_mul(fb, GEN_POL[0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MSG;
      beat_cnt <= '0;
      par_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= s_xfer && (bus.s_last != msg_end);
      case (state)
        MSG: begin
          if (s_xfer) begin
            par_q <= par_upd;
            if (msg_end) begin
              state    <= PAR;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        PAR: begin
          if (bus.m_ready) begin
            if (par_end) begin
              state    <= MSG;
              beat_cnt <= '0;
              par_q    <= '0;
            end else begin
              par_q    <= par_q << (LANES * SYM_W);
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= MSG;
      endcase
    end
  end

  assign bus.s_ready = !rst && (state == MSG) && bus.m_ready;
  assign bus.m_valid = !rst && ((state == PAR) || bus.s_valid);
  assign bus.m_data  = (state == PAR) ? par_q[PAR_LEN-1 -: LANES] : msg_beat;
  assign bus.m_first = !rst && (state == MSG) && beat0;
  assign bus.m_par   = (state == PAR);
  assign bus.m_last  = (state == PAR) && par_end;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_enc_pro_stream.sv
// Directed + randomized bench for enc_pro_stream in the RS(15,11) GF(16) two-lane configuration.
module tb_enc_pro_stream;

  localparam int SYM_W     = 4;
  localparam int MES_LEN   = 11;
  localparam int PAR_LEN   = 4;
  localparam int LANES     = 2;
  localparam int R         = (MES_LEN % LANES == 0) ? LANES : (MES_LEN % LANES);
  localparam int MSG_BEATS = (MES_LEN + LANES - 1) / LANES;
  localparam int PAR_BEATS = PAR_LEN / LANES;
  localparam int NBEATS    = MSG_BEATS + PAR_BEATS;
  localparam logic [SYM_W:0]                PRI_POL = 5'h13;
  localparam logic [PAR_LEN-1:0][SYM_W-1:0] GEN_POL = {4'd15, 4'd3, 4'd1, 4'd12};

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [2+LANES*SYM_W:0] obs_t;   // {m_par, m_first, m_last, m_data}

  logic clk = 1'b0;
  logic rst;

  enc_pro_stream_if #(.LANES(LANES), .SYM_W(SYM_W)) bus ();

  enc_pro_stream #(
    .SYM_W(SYM_W), .PRI_POL(PRI_POL), .MES_LEN(MES_LEN),
    .PAR_LEN(PAR_LEN), .LANES(LANES), .GEN_POL(GEN_POL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  int   gexp[30];
  int   glog[16];
  sym_t msg[MES_LEN];
  obs_t exp_q[$];
  obs_t obs_q[$];
  int   err_seen = 0;
  obs_t cur_beat;
  obs_t prev_beat;
  logic prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic sym_t gmul(input sym_t a, input sym_t b);
    if (a == 0 || b == 0) return '0;
    return sym_t'(gexp[glog[a] + glog[b]]);
  endfunction

  function automatic int sym_idx(input int b, input int l);
    return b * LANES - (LANES - R) + (LANES - 1 - l);
  endfunction

  // Reference: codeword remainder by polynomial long division, then sliced into beats.
  function automatic void build_expected();
    sym_t rem[MES_LEN+PAR_LEN];
    sym_t gfull[PAR_LEN+1];
    sym_t c;
    logic [LANES-1:0][SYM_W-1:0] d;
    for (int t = 0; t < PAR_LEN; t++) gfull[t] = GEN_POL[t];
    gfull[PAR_LEN] = 1;
    for (int i = 0; i < MES_LEN + PAR_LEN; i++) rem[i] = (i < MES_LEN) ? msg[i] : '0;
    for (int i = 0; i < MES_LEN; i++) begin
      c = rem[i];
      for (int j = 0; j <= PAR_LEN; j++) rem[i+j] = rem[i+j] ^ gmul(c, gfull[PAR_LEN-j]);
    end
    exp_q.delete();
    for (int b = 0; b < MSG_BEATS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        int idx;
        idx = sym_idx(b, l);
        if (idx < 0) d[l] = '0;
        else d[l] = msg[idx];
      end
      exp_q.push_back({1'b0, (b == 0), 1'b0, d});
    end
    for (int q = 0; q < PAR_BEATS; q++) begin
      for (int l = 0; l < LANES; l++) d[l] = rem[MES_LEN + q*LANES + (LANES-1-l)];
      exp_q.push_back({1'b1, 1'b0, (q == PAR_BEATS-1), d});
    end
  endfunction

  function automatic logic [LANES*SYM_W-1:0] beat_data(input int b);
    logic [LANES-1:0][SYM_W-1:0] v;
    for (int l = 0; l < LANES; l++) begin
      int idx;
      idx = sym_idx(b, l);
      if (idx < 0) v[l] = sym_t'($urandom);
      else v[l] = msg[idx];
    end
    return v;
  endfunction

  // Output monitor: collects transferred beats, counts err cycles, checks hold during stalls.
  always @(negedge clk) begin
    cur_beat = {bus.m_par, bus.m_first, bus.m_last, bus.m_data};
    if (prev_stall && !rst) chk("stall_hold", {bus.m_valid, cur_beat}, {1'b1, prev_beat});
    if (bus.err) err_seen++;
    if (bus.m_valid && bus.m_ready) obs_q.push_back(cur_beat);
    prev_stall = bus.m_valid && !bus.m_ready && !rst;
    prev_beat  = cur_beat;
  end

  task automatic send_beats(input int nbeats, input int last_mask, input bit rnd_rdy, input bit gaps);
    bit acc;
    int guard;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        bus.s_data  = LANES*SYM_W'($urandom);
        bus.m_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = beat_data(b);
      bus.s_last  = last_mask[b];
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 100) begin
        bus.m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        acc = bus.s_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = LANES*SYM_W'($urandom);
  endtask

  task automatic run_frame(input string tag, input int last_mask, input bit rnd_rdy, input bit gaps);
    int guard;
    int n;
    build_expected();
    obs_q.delete();
    err_seen = 0;
    send_beats(MSG_BEATS, last_mask, rnd_rdy, gaps);
    chk({tag, "_par_latency"}, {bus.m_valid, bus.m_par}, 2'b11);
    guard = 0;
    while (obs_q.size() < NBEATS && guard < 200) begin
      bus.m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_beat_count"}, obs_q.size(), NBEATS);
    n = (obs_q.size() < NBEATS) ? obs_q.size() : NBEATS;
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
    chk({tag, "_err_count"}, err_seen,
        $countones((last_mask ^ (1 << (MSG_BEATS-1))) & ((1 << MSG_BEATS) - 1)));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_flags"}, {bus.m_first, bus.m_last, bus.m_par}, 3'b000);
  endtask

  initial begin
    int v;
    sym_t a_msg[MES_LEN];
    sym_t b_msg[MES_LEN];
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v;
      gexp[i+15] = v;
      glog[v] = i;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 'h13;
    end

    // Reset state, with upstream offering data and downstream ready.
    bus.s_valid = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: all-zero message.
    for (int i = 0; i < MES_LEN; i++) msg[i] = '0;
    run_frame("t1_zero", 1 << (MSG_BEATS-1), 1'b0, 1'b0);

    // 2: single 1 in the last message symbol yields the generator coefficients.
    msg[MES_LEN-1] = 1;
    run_frame("t2_unit", 1 << (MSG_BEATS-1), 1'b0, 1'b0);
    if (obs_q.size() == NBEATS) begin
      chk("t2_par_hi", obs_q[MSG_BEATS][LANES*SYM_W-1:0], {GEN_POL[3], GEN_POL[2]});
      chk("t2_par_lo", obs_q[MSG_BEATS+1][LANES*SYM_W-1:0], {GEN_POL[1], GEN_POL[0]});
    end else begin
      chk("t2_par_present", obs_q.size(), NBEATS);
    end

    // 3: A, B and A^B back to back.
    for (int i = 0; i < MES_LEN; i++) begin
      a_msg[i] = sym_t'($urandom);
      b_msg[i] = sym_t'($urandom);
    end
    msg = a_msg;
    run_frame("t3_a", 1 << (MSG_BEATS-1), 1'b0, 1'b0);
    msg = b_msg;
    run_frame("t3_b", 1 << (MSG_BEATS-1), 1'b0, 1'b0);
    for (int i = 0; i < MES_LEN; i++) msg[i] = a_msg[i] ^ b_msg[i];
    run_frame("t3_ab", 1 << (MSG_BEATS-1), 1'b0, 1'b0);

    // 4: random backpressure and upstream gaps over 20 codewords.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < MES_LEN; i++) msg[i] = sym_t'($urandom);
      run_frame($sformatf("t4_f%0d", f), 1 << (MSG_BEATS-1), 1'b1, 1'b1);
    end

    // 5: spurious s_last on beat 3; framing follows the counter.
    for (int i = 0; i < MES_LEN; i++) msg[i] = sym_t'($urandom);
    run_frame("t5_slast", (1 << 3) | (1 << (MSG_BEATS-1)), 1'b0, 1'b0);

    // 6: reset mid-frame after three beats, then a fresh frame.
    for (int i = 0; i < MES_LEN; i++) msg[i] = sym_t'($urandom);
    bus.m_ready = 1'b1;
    send_beats(3, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    bus.s_valid = 1'b1;
    #1;
    check_reset_outputs("t6_rst_async");
    @(posedge clk); #1;
    chk("t6_rst_edge_m_valid", bus.m_valid, 0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < MES_LEN; i++) msg[i] = sym_t'($urandom);
    run_frame("t6_after_rst", 1 << (MSG_BEATS-1), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
